// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
package serial_adder_pkg;

  // State encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder built from two half-adder stages and an OR for the carry.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic ha0_s, ha0_c;
  logic ha1_s, ha1_c;

  // First half adder: a + b
  assign ha0_s = a_i ^ b_i;
  assign ha0_c = a_i & b_i;

  // Second half adder: partial sum + carry-in
  assign ha1_s = ha0_s ^ c_i;
  assign ha1_c = ha0_s & c_i;

  assign s_o = ha1_s;
  assign c_o = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one bit per clock through a single full-adder slice.
// WIDTH legal range is 2..64.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned         CntW    = clog2(WIDTH);
  localparam logic [CntW-1:0]     LastBit = CntW'(WIDTH - 1);

  state_e            state_q;
  logic [WIDTH-1:0]  a_sh_q, b_sh_q, sum_q;
  logic [CntW-1:0]   cnt_q;
  logic              c_q;
  logic              carry_q, overflow_q;
  logic              busy_q, done_q;

  logic              slice_s, slice_c;
  logic              accept;

  // A new operation is only accepted when not mid-computation.
  assign accept = start_i && (state_q == StIdle || state_q == StDone);

  fa_cell u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (c_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  // FSM, shift registers, counter and registered result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
      state_q <= StRun;
      a_sh_q  <= a_i;
      b_sh_q  <= b_i ^ {WIDTH{sub_i}};
      c_q     <= sub_i;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          sum_q  <= {slice_s, sum_q[WIDTH-1:1]};
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q    <= slice_c;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            // c_q here is the carry into the MSB.
            carry_q    <= slice_c;
            overflow_q <= c_q ^ slice_c;
            state_q    <= StDone;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sum_o      = sum_q;
  assign carry_o    = carry_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a, b;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             carry, overflow;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .sub_i      (sub),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .sum_o      (sum),
    .carry_o    (carry),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic msub,
                       output logic [7:0] s, output logic c, output logic v);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!msub) begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 255);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end
    s = ur[7:0];
    v = (sr > 127) || (sr < -128);
  endtask

  // Present an operation for one edge; returns #1 after the sampling edge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic isub);
    start = 1'b1;
    a     = ia;
    b     = ib;
    sub   = isub;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done; lat counts edges after the current sample point, -1 on timeout.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy && done) check("busy_done_overlap", 1, 0);
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk);
      #1;
    end
  endtask

  vec_t       vecs[5];
  int         lat, bcnt;
  logic [7:0] es;
  logic       ec, ev;
  logic [7:0] ra, rb;
  logic       rs;
  int         seen_done;

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_carry", carry, 0);
    check("reset_ovf", overflow, 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(lat, bcnt);
      check($sformatf("vec%0d_latency", i), lat, WIDTH);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, WIDTH);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("vec%0d_carry", i), carry, vecs[i].carry);
      check($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_hold_sum", i), sum, vecs[i].sum);
    end

    // start re-pulsed during RUN must be ignored
    issue(8'h11, 8'h22, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue(8'hFF, 8'hFF, 1'b1);
    wait_done(lat, bcnt);
    check("ignore_latency", lat + 3, WIDTH);
    check("ignore_sum", sum, 8'h33);
    check("ignore_carry", carry, 0);

    // Back-to-back: start during DONE
    issue(8'h40, 8'h02, 1'b0);
    wait_done(lat, bcnt);
    check("b2b_first_sum", sum, 8'h42);
    issue(8'h01, 8'h02, 1'b0);
    check("b2b_no_idle_busy", busy, 1);
    check("b2b_no_idle_done", done, 0);
    wait_done(lat, bcnt);
    check("b2b_latency", lat, WIDTH);
    check("b2b_sum", sum, 8'h03);

    // Leave nonzero result/flags, then abort with a mid-RUN reset
    issue(8'h80, 8'h01, 1'b1);
    wait_done(lat, bcnt);
    check("pre_rst_carry", carry, 1);
    @(posedge clk); #1;
    issue(8'h55, 8'h66, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry, 0);
    check("rst_ovf", overflow, 0);
    seen_done = 0;
    for (int n = 0; n < 15; n++) begin
      if (done || busy) seen_done++;
      @(posedge clk); #1;
    end
    check("rst_no_done", seen_done, 0);
    issue(8'h10, 8'h20, 1'b0);
    wait_done(lat, bcnt);
    check("post_rst_latency", lat, WIDTH);
    check("post_rst_sum", sum, 8'h30);

    // Randomised operations against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, es, ec, ev);
      issue(ra, rb, rs);
      wait_done(lat, bcnt);
      check($sformatf("rnd%0d_latency", i), lat, WIDTH);
      check($sformatf("rnd%0d_sum a=%0h b=%0h sub=%0d", i, ra, rb, rs), sum, es);
      check($sformatf("rnd%0d_carry a=%0h b=%0h sub=%0d", i, ra, rb, rs), carry, ec);
      check($sformatf("rnd%0d_ovf a=%0h b=%0h sub=%0d", i, ra, rb, rs), overflow, ev);
      // Half the time go through IDLE, otherwise restart straight from DONE.
      if ($urandom_range(1, 0) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
